// File: rtl/div_seq_pkg.sv
// Shared types and defaults for the sequential divider sequencer.
//   state_e           : sequencer FSM states
//   CoreCyclesDefault : core edges (with core_resetn high) until its results are final
//   DbzQuot           : quotient reported when the divisor is zero
package div_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StCapture
    } state_e;

    localparam int unsigned CoreCyclesDefault = 34;
    localparam logic [31:0] DbzQuot           = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between a requester and div_seq.
//   start        : request a division (honoured only while the sequencer is idle)
//   op_a, op_b   : signed dividend / divisor
//   busy         : sequencer not idle
//   done         : one-cycle pulse when z_out is refreshed
//   dbz          : last operation was a divide-by-zero
//   z_out        : {remainder, quotient}, held between operations
interface div_seq_if;
    import div_seq_pkg::*;

    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [63:0] z_out;

    modport master (
        output start, op_a, op_b,
        input  busy, done, dbz, z_out
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, dbz, z_out
    );

endinterface

// File: rtl/div_sign_fix.sv
// Applies a sign to an unsigned magnitude (two's complement, modulo 2^32).
//   mag_i : magnitude
//   neg_i : 1 -> negate
//   val_o : signed result
module div_sign_fix (
    input  logic [31:0] mag_i,
    input  logic        neg_i,
    output logic [31:0] val_o
);

    always_comb begin
        val_o = neg_i ? (~mag_i + 32'd1) : mag_i;
    end

endmodule

// File: rtl/div_seq.sv
// Sequencer around an external iterative signed divider core.
// Latches operands, restarts the core for one cycle, waits a fixed number of
// core edges, then captures {signed remainder, quotient}. A zero divisor
// bypasses the core and reports {dividend, DBZ_QUOT} with dbz set.
//   clk, resetn          : clock, asynchronous active-low reset
//   bus (slave)          : start/op_a/op_b in, busy/done/dbz/z_out out
//   core_q, core_m       : latched dividend / divisor driven to the core
//   core_resetn          : synchronous active-low restart of the core
//   core_quotient        : core quotient, already sign-corrected
//   core_remainder       : core remainder magnitude
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned CORE_CYCLES = CoreCyclesDefault,
    parameter logic [31:0] DBZ_QUOT    = DbzQuot
) (
    input  logic        clk,
    input  logic        resetn,
    div_seq_if.slave    bus,
    output logic [31:0] core_q,
    output logic [31:0] core_m,
    output logic        core_resetn,
    input  logic [31:0] core_quotient,
    input  logic [31:0] core_remainder
);

    localparam logic [5:0] RunLast = 6'(CORE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] a_hold_q, a_hold_d;      // dividend kept for the divide-by-zero result
    logic        dbz_pend_q, dbz_pend_d;  // current operation bypasses the core
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic [63:0] z_q, z_d;
    logic        core_resetn_q, core_resetn_d;
    logic [31:0] rem_signed;

    // Remainder takes the sign of the latched dividend.
    div_sign_fix u_sign_fix (
        .mag_i (core_remainder),
        .neg_i (opa_q[31]),
        .val_o (rem_signed)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (bus.op_b != 32'd0) ? StLoad : StCapture;
                end
            end
            StLoad:    state_d = StRun;
            StRun: begin
                if (cnt_q == RunLast) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        a_hold_d   = a_hold_q;
        dbz_pend_d = dbz_pend_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        z_d        = z_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_hold_d   = bus.op_a;
                    dbz_pend_d = (bus.op_b == 32'd0);
                    if (bus.op_b != 32'd0) begin
                        opa_d = bus.op_a;
                        opb_d = bus.op_b;
                    end
                end
            end
            StLoad: cnt_d = 6'd0;
            StRun:  cnt_d = cnt_q + 6'd1;
            StCapture: begin
                done_d = 1'b1;
                if (dbz_pend_q) begin
                    z_d   = {a_hold_q, DBZ_QUOT};
                    dbz_d = 1'b1;
                end else begin
                    z_d   = {rem_signed, core_quotient};
                    dbz_d = 1'b0;
                end
            end
            default: ;
        endcase
        // Registered so the core sees exactly one low cycle, aligned with LOAD.
        core_resetn_d = (state_d != StLoad);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= 6'd0;
            opa_q         <= 32'd0;
            opb_q         <= 32'd0;
            a_hold_q      <= 32'd0;
            dbz_pend_q    <= 1'b0;
            done_q        <= 1'b0;
            dbz_q         <= 1'b0;
            z_q           <= 64'd0;
            core_resetn_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            a_hold_q      <= a_hold_d;
            dbz_pend_q    <= dbz_pend_d;
            done_q        <= done_d;
            dbz_q         <= dbz_d;
            z_q           <= z_d;
            core_resetn_q <= core_resetn_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.dbz     = dbz_q;
    assign bus.z_out   = z_q;
    assign core_q      = opa_q;
    assign core_m      = opb_q;
    assign core_resetn = core_resetn_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq with a behavioural iterative divider core.
module tb_div_seq;

    localparam int CC  = 34;
    localparam int Lat = CC + 2;

    typedef struct packed {
        logic [63:0] z;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] core_q, core_m, core_quotient, core_remainder;
    logic        core_resetn;
    int          core_cnt;
    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    exp_t        sb[$];

    div_seq_if bus ();

    div_seq #(
        .CORE_CYCLES (CC),
        .DBZ_QUOT    (32'hFFFF_FFFF)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .core_q         (core_q),
        .core_m         (core_m),
        .core_resetn    (core_resetn),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder)
    );

    always #5 clk = ~clk;

    // Core model: results become valid only on the CC-th edge after restart.
    function automatic logic [63:0] core_calc(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, qm, q;
        if (b == 32'd0) return 64'd0;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        qm = ma / mb;
        q  = (a[31] ^ b[31]) ? -qm : qm;
        return {ma % mb, q};
    endfunction

    always @(posedge clk) begin
        if (!core_resetn) begin
            core_cnt       <= 0;
            core_quotient  <= 32'hDEAD_BEEF;
            core_remainder <= 32'h0BAD_F00D;
        end else if (core_cnt < CC) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == CC - 1) begin
                {core_remainder, core_quotient} <= core_calc(core_q, core_m);
            end else begin
                core_quotient  <= 32'hDEAD_BEEF ^ 32'(core_cnt);
                core_remainder <= 32'h0BAD_F00D ^ 32'(core_cnt);
            end
        end
    end

    always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    // Reference: remainder derived as a - q*b, independent of the core's method.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] q;
        if (b == 32'd0) begin
            e.z   = {a, 32'hFFFF_FFFF};
            e.dbz = 1'b1;
            return e;
        end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) q = 32'h8000_0000;
        else q = $signed(a) / $signed(b);
        e.z   = {a - q * b, q};
        e.dbz = 1'b0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge (edge 0).
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit push);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        if (push) sb.push_back(ref_div(a, b));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Starting at the negedge after edge k0, returns the edge index where done is seen.
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (bus.done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.dbz, core_resetn} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.dbz, core_resetn});
        else n_pass++;
        n_checks++;
        if (bus.z_out !== 64'd0) $display("FAIL reset_z: got %h want 0", bus.z_out);
        else n_pass++;
        n_checks++;
        if ({core_q, core_m} !== 64'd0) $display("FAIL reset_core_ops: got %h want 0", {core_q, core_m});
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, core_resetn} !== 2'b01)
            $display("FAIL idle_after_reset: got busy,core_resetn=%b want 01", {bus.busy, core_resetn});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] ta[2] = '{32'd38, 32'hFFFF_FFDA};
        exp_t e;
        int   k;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            do_start(ta[i], 32'd6, 1'b1);
            n_checks++;
            if ({bus.busy, core_resetn, core_q, core_m} !== {2'b10, ta[i], 32'd6})
                $display("FAIL basic%0d_load: got %b/%h/%h", i, {bus.busy, core_resetn}, core_q, core_m);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.busy, core_resetn} !== 2'b11)
                $display("FAIL basic%0d_run: got busy,core_resetn=%b want 11", i, {bus.busy, core_resetn});
            else n_pass++;
            wait_done(1, k);
            n_checks++;
            if (k !== Lat) $display("FAIL basic%0d_lat: got %0d edges want %0d", i, k, Lat);
            else n_pass++;
            e = sb.pop_front();
            n_checks++;
            if (bus.z_out !== e.z) $display("FAIL basic%0d_z: got %h want %h", i, bus.z_out, e.z);
            else n_pass++;
            n_checks++;
            if (bus.dbz !== e.dbz) $display("FAIL basic%0d_dbz: got %b want %b", i, bus.dbz, e.dbz);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.done, bus.busy} !== 2'b00 || bus.z_out !== e.z)
                $display("FAIL basic%0d_hold: got done,busy=%b z=%h want 00 z=%h", i,
                         {bus.done, bus.busy}, bus.z_out, e.z);
            else n_pass++;
        end
    endtask

    task automatic test_dbz();
        exp_t e;
        int   k;
        @(negedge clk);
        do_start(32'd7, 32'd0, 1'b1);
        n_checks++;
        if ({bus.busy, core_resetn} !== 2'b11)
            $display("FAIL dbz_capture: got busy,core_resetn=%b want 11", {bus.busy, core_resetn});
        else n_pass++;
        wait_done(0, k);
        n_checks++;
        if (k !== 1) $display("FAIL dbz_lat: got %0d edges want 1", k);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({bus.z_out, bus.dbz} !== {e.z, e.dbz})
            $display("FAIL dbz_result: got %h/%b want %h/%b", bus.z_out, bus.dbz, e.z, e.dbz);
        else n_pass++;
        n_checks++;
        if ({core_q, core_m} !== {32'hFFFF_FFDA, 32'd6})
            $display("FAIL dbz_core_ops: got %h/%h want ffffffda/00000006", core_q, core_m);
        else n_pass++;
        // Start on the done cycle: sampled on the edge right after done.
        do_start(32'd100, 32'd25, 1'b1);
        wait_done(0, k);
        n_checks++;
        if (k !== Lat) $display("FAIL dbz_next_lat: got %0d edges want %0d", k, Lat);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({bus.z_out, bus.dbz} !== {e.z, e.dbz})
            $display("FAIL dbz_next_result: got %h/%b want %h/%b", bus.z_out, bus.dbz, e.z, e.dbz);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   k, d0;
        @(negedge clk);
        d0 = done_cnt;
        do_start(32'd100, 32'd25, 1'b1);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({core_q, core_m} !== {32'd100, 32'd25})
            $display("FAIL ignore_core_ops: got %h/%h want 00000064/00000019", core_q, core_m);
        else n_pass++;
        wait_done(20, k);
        n_checks++;
        if (k !== Lat) $display("FAIL ignore_lat: got %0d edges want %0d", k, Lat);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (bus.z_out !== e.z) $display("FAIL ignore_z: got %h want %h", bus.z_out, e.z);
        else n_pass++;
        repeat (45) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL ignore_single_done: got %0d pulses want 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_abort();
        exp_t e;
        int   k, d0;
        @(negedge clk);
        d0 = done_cnt;
        do_start(32'd38, 32'd6, 1'b0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.dbz, core_resetn} !== 4'b0000 || bus.z_out !== 64'd0)
            $display("FAIL abort_outputs: got %b z=%h want 0000 z=0",
                     {bus.busy, bus.done, bus.dbz, core_resetn}, bus.z_out);
        else n_pass++;
        n_checks++;
        if ({core_q, core_m} !== 64'd0) $display("FAIL abort_core_ops: got %h want 0", {core_q, core_m});
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 0 || bus.busy !== 1'b0)
            $display("FAIL abort_no_done: got %0d pulses busy=%b want 0/0", done_cnt - d0, bus.busy);
        else n_pass++;
        do_start(32'd38, 32'd6, 1'b1);
        wait_done(0, k);
        n_checks++;
        if (k !== Lat) $display("FAIL abort_restart_lat: got %0d edges want %0d", k, Lat);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({bus.z_out, bus.dbz} !== {e.z, e.dbz})
            $display("FAIL abort_restart_result: got %h/%b want %h/%b", bus.z_out, bus.dbz, e.z, e.dbz);
        else n_pass++;
    endtask

    task automatic test_boundary();
        logic [31:0] ta[6] = '{32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
        logic [31:0] tb[6] = '{32'd1, 32'd50, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        exp_t e;
        int   k, want;
        for (int i = 3; i < 6; i++) begin
            ta[i] = $urandom;
            tb[i] = 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) tb[i] = -tb[i];
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            do_start(ta[i], tb[i], 1'b1);
            want = (tb[i] == 32'd0) ? 1 : Lat;
            wait_done(0, k);
            n_checks++;
            if (k !== want) $display("FAIL bound%0d_lat: got %0d edges want %0d", i, k, want);
            else n_pass++;
            e = sb.pop_front();
            n_checks++;
            if ({bus.z_out, bus.dbz} !== {e.z, e.dbz})
                $display("FAIL bound%0d_result (%h/%h): got %h/%b want %h/%b", i, ta[i], tb[i],
                         bus.z_out, bus.dbz, e.z, e.dbz);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   k, k2, d0;
        @(negedge clk);
        d0 = done_cnt;
        // Start held high throughout: second op must begin on the edge after done.
        bus.start = 1'b1;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'hFFFF_FFF9;
        sb.push_back(ref_div(32'd1000, 32'hFFFF_FFF9));
        @(posedge clk);
        @(negedge clk);
        bus.op_a = 32'hFFFF_FC19;
        bus.op_b = 32'd10;
        sb.push_back(ref_div(32'hFFFF_FC19, 32'd10));
        wait_done(0, k);
        n_checks++;
        if (k !== Lat) $display("FAIL b2b_first_lat: got %0d edges want %0d", k, Lat);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (bus.z_out !== e.z) $display("FAIL b2b_first_z: got %h want %h", bus.z_out, e.z);
        else n_pass++;
        @(negedge clk);
        wait_done(k + 1, k2);
        bus.start = 1'b0;
        n_checks++;
        if (k2 !== 2 * Lat + 1) $display("FAIL b2b_second_lat: got %0d edges want %0d", k2, 2 * Lat + 1);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (bus.z_out !== e.z) $display("FAIL b2b_second_z: got %h want %h", bus.z_out, e.z);
        else n_pass++;
        repeat (45) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count: got %0d pulses want 2", done_cnt - d0);
        else n_pass++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_a  = 32'd0;
        bus.op_b  = 32'd0;
        test_reset();
        test_basic();
        test_dbz();
        test_ignore_start();
        test_abort();
        test_boundary();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter CORE_CYCLES, default 34: rising edges, with core_resetn high, after which the divider core's outputs are final.
REQ-002 Parameter DBZ_QUOT, default 32'hFFFF_FFFF: quotient reported on divide-by-zero.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request a division; sampled only in IDLE.
REQ-006 op_a  in  32  signed dividend.
REQ-007 op_b  in  32  signed divisor.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when z_out is updated.
REQ-010 dbz  out  1  sticky divide-by-zero flag for the last operation.
REQ-011 z_out  out  64  {remainder[63:32], quotient[31:0]}, held between operations.
REQ-012 core_q, core_m  out  32 each  latched dividend/divisor to the iterative divider core.
REQ-013 core_resetn  out  1  active-low synchronous restart of the core.
REQ-014 core_quotient, core_remainder  in  32 each  core results: quotient already sign-corrected, remainder as magnitude.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN, CAPTURE.
REQ-016 IDLE with start=1 and op_b!=0: latch op_a/op_b into core_q/core_m and go to LOAD.
REQ-017 IDLE with start=1 and op_b==0: go to CAPTURE without running the core; z_out={op_a, DBZ_QUOT}; dbz=1.
REQ-018 LOAD: core_resetn=0 for exactly one cycle; cycle counter cleared; then RUN.
REQ-019 RUN: core_resetn=1; 6-bit counter increments each edge; leave to CAPTURE when counter reaches CORE_CYCLES-1.
REQ-020 CAPTURE: z_out[31:0]=core_quotient; z_out[63:32]=latched op_a[31] ? -core_remainder : core_remainder (remainder sign follows dividend); dbz=0; done=1; next state IDLE.
REQ-021 Latency: normal divide SHALL assert done exactly CORE_CYCLES+2 edges after the edge that samples start. Divide-by-zero SHALL assert done 1 edge after that edge.
REQ-022 core_q/core_m SHALL stay stable from LOAD through CAPTURE; op_a/op_b changes while busy are ignored.
REQ-023 start while busy SHALL be ignored, not queued.
REQ-024 A new start SHALL be accepted no earlier than the edge after done; back-to-back throughput is one operation per CORE_CYCLES+3 cycles.
REQ-025 Negation is two's complement modulo 2^32; -2^31/-1 yields quotient 0x8000_0000 with no flag.
REQ-026 core_resetn SHALL be 1 in IDLE and CAPTURE, so the core holds its last result.

Reset
REQ-027 resetn low SHALL asynchronously force: state=IDLE, counter=0, busy=0, done=0, dbz=0, z_out=0, core_q=0, core_m=0, core_resetn=0.
REQ-028 Reset mid-operation SHALL abort with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-029 Package div_seq_pkg SHALL hold the state enum, the CORE_CYCLES default and DBZ_QUOT.
REQ-030 Remainder sign correction SHALL be a sub-module div_sign_fix (pure combinational: magnitude plus sign in, signed value out).
REQ-031 The divider core is instantiated by the parent alongside div_seq, not inside it.

Verification
REQ-032 op_a=38, op_b=6, start 1 cycle -> done at edge 36; z_out=64'h00000002_00000006; dbz=0.
REQ-033 op_a=-38, op_b=6 -> z_out=64'hFFFFFFFE_FFFFFFFA.
REQ-034 op_a=7, op_b=0 -> done 1 edge later; z_out=64'h00000007_FFFFFFFF; dbz=1. A following 100/25 -> z_out=64'h00000000_00000004, dbz=0.
REQ-035 100/25 started, start re-pulsed with 9/3 at edge 10 -> single done at edge 36, z_out=64'h00000000_00000004.
REQ-036 resetn pulsed low at edge 20 of 38/6 -> outputs zero immediately, no done; restarting 38/6 gives the REQ-032 result.
REQ-037 0x7FFFFFFF/1 -> z_out=64'h00000000_7FFFFFFF; 1/50 -> z_out=64'h00000001_00000000.
